// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings,
// default operand width and the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus between a controlling FSM
// (master) and the serial subtractor (slave).
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             V;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Bout, V
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Bout, V
    );
endinterface

// File: rtl/serial_subtractor_full_adder.sv
// One-bit full-adder cell; the subtractor's only arithmetic element.
module Full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, Diff = A + ~B + 1, LSB first.
// Optional macro SERIAL_SUB_SAT_EN saturates Diff on signed overflow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             fa_s;
    logic             fa_co;

    Full_adder u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state, datapath and result-register logic
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    sa_d    = bus.A;
                    sb_d    = ~bus.B;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                carry_d = fa_co;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q is the carry into the MSB on this final bit
                    state_d = ST_DONE;
                    diff_d  = res_d;
                    bout_d  = ~fa_co;
                    v_d     = fa_co ^ carry_q;
`ifdef SERIAL_SUB_SAT_EN
                    if (v_d) begin
                        diff_d = res_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                : {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        diff_d = res_d;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   checks_cnt;
    int   err_cnt;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present operands with start, return #1 after the capture edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        sif.A     = a;
        sif.B     = b;
        sif.start = 1'b1;
        @(posedge clk);
        #1;
        sif.start = 1'b0;
        sif.A     = ~a;
        sif.B     = ~b;
    endtask

    // Track an operation from just after its capture edge to the DONE cycle.
    task automatic finish_op(input string tag, input logic [W-1:0] exp_d, input logic exp_bout,
                             input logic exp_v, input logic [W-1:0] prev_d, input logic junk);
        check_val({tag, "_busy0"}, sif.busy, 1'b1);
        check_val({tag, "_hold0"}, sif.Diff, prev_d);
        for (int i = 1; i < W; i++) begin
            if (junk) begin
                sif.start = 1'b1;
                sif.A     = 4'hF;
                sif.B     = 4'h0;
            end
            @(posedge clk);
            #1;
            check_val({tag, "_busy"}, sif.busy, 1'b1);
            check_val({tag, "_nodone"}, sif.done, 1'b0);
            check_val({tag, "_hold"}, sif.Diff, prev_d);
        end
        sif.start = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_done"}, sif.done, 1'b1);
        check_val({tag, "_idle"}, sif.busy, 1'b0);
        check_val({tag, "_diff"}, sif.Diff, exp_d);
        check_val({tag, "_bout"}, sif.Bout, exp_bout);
        check_val({tag, "_v"}, sif.V, exp_v);
    endtask

    task automatic done_drops(input string tag, input logic [W-1:0] exp_d);
        @(posedge clk);
        #1;
        check_val({tag, "_pulse"}, sif.done, 1'b0);
        check_val({tag, "_stable"}, sif.Diff, exp_d);
    endtask

    logic [W-1:0] neg_ovf_d;
    logic [W-1:0] pos_ovf_d;

    initial begin
        checks_cnt = 0;
        err_cnt    = 0;
`ifdef SERIAL_SUB_SAT_EN
        neg_ovf_d = 4'b1000;
        pos_ovf_d = 4'b0111;
`else
        neg_ovf_d = 4'b0111;
        pos_ovf_d = 4'b1000;
`endif
        sif.start = 1'b0;
        sif.A     = 4'h0;
        sif.B     = 4'h0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", sif.busy, 1'b0);
        check_val("rst_done", sif.done, 1'b0);
        check_val("rst_diff", sif.Diff, 4'h0);
        check_val("rst_bout", sif.Bout, 1'b0);
        check_val("rst_v", sif.V, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        start_op(4'b0101, 4'b0011);
        finish_op("basic", 4'b0010, 1'b0, 1'b0, 4'h0, 1'b0);
        done_drops("basic", 4'b0010);

        start_op(4'b0011, 4'b0101);
        finish_op("borrow", 4'b1110, 1'b1, 1'b0, 4'b0010, 1'b0);
        done_drops("borrow", 4'b1110);

        start_op(4'b1000, 4'b0001);
        finish_op("negovf", neg_ovf_d, 1'b0, 1'b1, 4'b1110, 1'b0);
        done_drops("negovf", neg_ovf_d);

        start_op(4'b0111, 4'b1111);
        finish_op("posovf", pos_ovf_d, 1'b1, 1'b1, neg_ovf_d, 1'b0);
        done_drops("posovf", pos_ovf_d);

        start_op(4'b0000, 4'b0001);
        finish_op("zero_m1", 4'b1111, 1'b1, 1'b0, pos_ovf_d, 1'b0);
        done_drops("zero_m1", 4'b1111);

        // Start re-asserted with other operands while busy must be ignored
        start_op(4'b0101, 4'b0011);
        finish_op("ignore", 4'b0010, 1'b0, 1'b0, 4'b1111, 1'b1);
        // Start presented in the DONE cycle begins the next op immediately
        start_op(4'b0110, 4'b0110);
        finish_op("b2b", 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b0);
        done_drops("b2b", 4'b0000);

        start_op(4'b0111, 4'b0001);
        finish_op("pre_rst", 4'b0110, 1'b0, 1'b0, 4'b0000, 1'b0);
        done_drops("pre_rst", 4'b0110);

        // Reset asserted two cycles into SHIFT aborts the operation
        start_op(4'b1000, 4'b0001);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("abort_busy", sif.busy, 1'b0);
        check_val("abort_done", sif.done, 1'b0);
        check_val("abort_diff", sif.Diff, 4'h0);
        check_val("abort_bout", sif.Bout, 1'b0);
        check_val("abort_v", sif.V, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            check_val("abort_nodone", sif.done, 1'b0);
        end

        start_op(4'b0011, 4'b0101);
        finish_op("post_rst", 4'b1110, 1'b1, 1'b0, 4'h0, 1'b0);
        done_drops("post_rst", 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, err_cnt);
        $finish;
    end
endmodule
